// File: rtl/audio_looper_mc.sv
// Multi-channel loop recorder/player: records strobed frames, plays them forward or
// reversed, and overdubs with per-channel saturation. Advances only on sample_en.

module audio_looper_mc_sat #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  logic [W:0] sum;

  assign sum = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  always_comb begin
    if (sum[W] != sum[W-1]) y_o = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                    y_o = sum[W-1:0];
  end
endmodule

module audio_looper_mc #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   in,
  input  logic                           write,
  input  logic                           overdub,
  input  logic                           read,
  input  logic                           reverse,
  output logic [NUM_CH*DATA_WIDTH-1:0]   out,
  output logic                           out_valid,
  output logic [ADDR_WIDTH:0]            loop_len,
  output logic [2:0]                     state,
  output logic                           full
);
  localparam int FW    = NUM_CH*DATA_WIDTH;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_L   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    EMPTY = 3'd0, RECORD = 3'd1, IDLE = 3'd2, PLAY = 3'd3, OVERDUB = 3'd4
  } state_e;
  typedef enum logic [1:0] {ACT_PASS, ACT_REC, ACT_PLAY, ACT_OVD} act_e;

  state_e                state_q, state_d;
  act_e                  act;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr, last, start, step, rec_ptr;
  logic [ADDR_WIDTH:0]   len_q, len_d, rec_len;
  logic                  wblk_q, wblk_d;
  logic                  pend_q, vld_q;
  logic                  cw_q, co_q, cr_q, crv_q;
  logic                  cw, co, cr, crv, ew;
  logic [FW-1:0]         in_q, rd_q, out_q, ovd;
  logic [FW-1:0]         mem [DEPTH];

  // Commands are live in the strobe cycle and replayed from capture in the commit
  // cycle; state does not move in between, so both cycles decode identically.
  assign cw  = sample_en ? write   : cw_q;
  assign co  = sample_en ? overdub : co_q;
  assign cr  = sample_en ? read    : cr_q;
  assign crv = sample_en ? reverse : crv_q;
  assign ew  = cw & ~wblk_q;

  assign last    = len_q[ADDR_WIDTH-1:0] - ONE_A;
  assign start   = crv ? last : '0;
  assign step    = crv ? ((ptr_q == '0) ? last : ptr_q - ONE_A)
                       : ((ptr_q == last) ? '0 : ptr_q + ONE_A);
  assign rec_ptr = (state_q == RECORD) ? ptr_q : '0;
  assign rec_len = (state_q == RECORD) ? len_q : '0;

  always_comb begin
    act     = ACT_PASS;
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    addr    = ptr_q;
    wblk_d  = cw ? wblk_q : 1'b0;
    if (ew) begin
      act = ACT_REC;
    end else begin
      case (state_q)
        RECORD: state_d = (len_q != '0) ? IDLE : EMPTY;
        IDLE: begin
          if (co)      begin act = ACT_OVD;  addr = start; end
          else if (cr) begin act = ACT_PLAY; addr = start; end
        end
        PLAY, OVERDUB: begin
          if (co)      begin act = ACT_OVD;  addr = step; end
          else if (cr) begin act = ACT_PLAY; addr = step; end
          else         state_d = IDLE;
        end
        default: ;
      endcase
    end
    case (act)
      ACT_REC: begin
        addr  = rec_ptr;
        ptr_d = rec_ptr + ONE_A;
        len_d = rec_len + ONE_L;
        if (len_d == DEPTH_L) begin
          state_d = IDLE;
          ptr_d   = '0;
          wblk_d  = 1'b1;
        end else begin
          state_d = RECORD;
        end
      end
      ACT_PLAY: begin state_d = PLAY;    ptr_d = addr; end
      ACT_OVD:  begin state_d = OVERDUB; ptr_d = addr; end
      default: ;
    endcase
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    audio_looper_mc_sat #(.W(DATA_WIDTH)) u_sat (
      .a_i(rd_q[k*DATA_WIDTH +: DATA_WIDTH]),
      .b_i(in_q[k*DATA_WIDTH +: DATA_WIDTH]),
      .y_o(ovd[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      len_q   <= '0;
      wblk_q  <= 1'b0;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
      out_q   <= '0;
      in_q    <= '0;
      cw_q    <= 1'b0;
      co_q    <= 1'b0;
      cr_q    <= 1'b0;
      crv_q   <= 1'b0;
    end else begin
      pend_q <= sample_en;
      vld_q  <= pend_q;
      if (sample_en) begin
        in_q  <= in;
        cw_q  <= write;
        co_q  <= overdub;
        cr_q  <= read;
        crv_q <= reverse;
      end
      if (pend_q) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        len_q   <= len_d;
        wblk_q  <= wblk_d;
        out_q   <= (act == ACT_PLAY) ? rd_q : (act == ACT_OVD) ? ovd : in_q;
      end
    end
  end

  // Buffer survives reset; read in the strobe cycle, write-back in the commit cycle.
  always_ff @(posedge clk) begin
    if (sample_en) rd_q <= mem[addr];
    if (pend_q && (act == ACT_REC || act == ACT_OVD))
      mem[addr] <= (act == ACT_REC) ? in_q : ovd;
  end

  a_strobe_spacing: assert property (@(posedge clk) disable iff (!reset) pend_q |-> !sample_en);

  assign out       = out_q;
  assign out_valid = vld_q;
  assign loop_len  = len_q;
  assign state     = state_q;
  assign full      = (len_q == DEPTH_L);
endmodule

// File: tb/tb_audio_looper_mc.sv
// Bench for audio_looper_mc: vector table, directed corner sequences and a randomized
// run checked against a frame-level reference model.

module tb_audio_looper_mc;
  localparam int DW = 24, NCH = 2, AW = 4;
  localparam int FW = NCH*DW, DEPTH = 2**AW;
  localparam int S_EMPTY = 0, S_REC = 1, S_IDLE = 2, S_PLAY = 3, S_OVD = 4;

  logic          clk = 1'b0, reset = 1'b0, sample_en = 1'b0;
  logic [FW-1:0] in = '0, out;
  logic          write = 1'b0, overdub = 1'b0, read = 1'b0, reverse = 1'b0;
  logic          out_valid, full;
  logic [AW:0]   loop_len;
  logic [2:0]    state;

  audio_looper_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .in(in),
    .write(write), .overdub(overdub), .read(read), .reverse(reverse),
    .out(out), .out_valid(out_valid), .loop_len(loop_len), .state(state), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: the loop is an array of frames appended while recording.
  logic [FW-1:0] m_mem [DEPTH];
  int m_st = S_EMPTY, m_len = 0, m_pos = 0;
  bit m_blk = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int c0, input int c1);
    logic [DW-1:0] a, b;
    a = c0[DW-1:0];
    b = c1[DW-1:0];
    return {b, a};
  endfunction

  function automatic int clamp(input int v);
    if (v > (1 << (DW-1)) - 1) return (1 << (DW-1)) - 1;
    if (v < -(1 << (DW-1)))    return -(1 << (DW-1));
    return v;
  endfunction

  task automatic model_reset();
    m_st = S_EMPTY; m_len = 0; m_pos = 0; m_blk = 0;
  endtask

  task automatic model(input bit w, o, r, rv, input logic [FW-1:0] d, output logic [FW-1:0] eo);
    bit ew;
    logic [FW-1:0] f;
    logic signed [DW-1:0] a, b;
    ew = w && !m_blk;
    if (!w) m_blk = 0;
    eo = d;
    if (ew) begin
      if (m_st != S_REC) m_len = 0;
      m_mem[m_len] = d;
      m_len++;
      m_st = S_REC;
      if (m_len == DEPTH) begin m_st = S_IDLE; m_blk = 1; end
    end else if (m_st == S_REC) begin
      m_st = (m_len > 0) ? S_IDLE : S_EMPTY;
    end else if (m_st == S_IDLE || m_st == S_PLAY || m_st == S_OVD) begin
      if (o || r) begin
        if (m_st == S_IDLE) m_pos = rv ? m_len - 1 : 0;
        else                m_pos = rv ? (m_pos + m_len - 1) % m_len : (m_pos + 1) % m_len;
        if (o) begin
          f = m_mem[m_pos];
          for (int k = 0; k < NCH; k++) begin
            a = f[k*DW +: DW];
            b = d[k*DW +: DW];
            f[k*DW +: DW] = DW'(clamp(int'(a) + int'(b)));
          end
          m_mem[m_pos] = f;
          m_st = S_OVD;
        end else begin
          m_st = S_PLAY;
        end
        eo = m_mem[m_pos];
      end else if (m_st != S_IDLE) begin
        m_st = S_IDLE;
      end
    end
  endtask

  // One strobe, then three idle cycles; out_valid must rise exactly one clk later.
  task automatic strobe(input bit w, o, r, rv, input logic [FW-1:0] d, output logic [FW-1:0] got);
    logic [FW-1:0] eo;
    write = w; overdub = o; read = r; reverse = rv; in = d; sample_en = 1'b1;
    @(posedge clk); #1 sample_en = 1'b0;
    chk("valid_early", 64'(out_valid), 64'(0));
    model(w, o, r, rv, d, eo);
    @(posedge clk); #1;
    chk("valid", 64'(out_valid), 64'(1));
    chk("out", 64'(out), 64'(eo));
    chk("state", 64'(state), 64'(m_st));
    chk("loop_len", 64'(loop_len), 64'(m_len));
    chk("full", 64'(full), 64'(m_len == DEPTH));
    got = out;
    @(posedge clk); #1 chk("valid_pulse", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit w, o, r, rv;
    int d0, d1;
    int e0, e1;
    int est, elen;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [FW-1:0] got;
    int exp_rev[6] = '{5, 4, 3, 2, 1, 5};
    int exp_tog[6] = '{5, 4, 3, 4, 5, 1};

    for (int i = 0; i < 5; i++) tbl[i] = '{1, 0, 0, 0, i+1, -(i+1), i+1, -(i+1), S_REC, i+1};
    tbl[5] = '{0, 0, 0, 0, 77, -77, 77, -77, S_IDLE, 5};
    for (int i = 6; i < 18; i++)
      tbl[i] = '{0, 0, 1, 0, 50+i, 9, ((i-6) % 5) + 1, -(((i-6) % 5) + 1), S_PLAY, 5};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_state", 64'(state), 64'(S_EMPTY));
    chk("rst_len", 64'(loop_len), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Record ramp, stop, then forward playback with wrap
    for (int i = 0; i < 18; i++) begin
      strobe(tbl[i].w, tbl[i].o, tbl[i].r, tbl[i].rv, mk(tbl[i].d0, tbl[i].d1), got);
      chk($sformatf("tbl%0d_out", i), 64'(got), 64'(mk(tbl[i].e0, tbl[i].e1)));
      chk($sformatf("tbl%0d_state", i), 64'(state), 64'(tbl[i].est));
      chk($sformatf("tbl%0d_len", i), 64'(loop_len), 64'(tbl[i].elen));
    end
    strobe(0, 0, 0, 0, mk(3, 3), got);

    // Reverse playback from IDLE
    for (int i = 0; i < 6; i++) begin
      strobe(0, 0, 1, 1, mk(0, 0), got);
      chk($sformatf("rev%0d", i), 64'(got), 64'(mk(exp_rev[i], -exp_rev[i])));
    end
    strobe(0, 0, 0, 0, mk(0, 0), got);

    // Direction change mid-play continues from the current frame
    for (int i = 0; i < 6; i++) begin
      strobe(0, 0, 1, (i < 3), mk(0, 0), got);
      chk($sformatf("tog%0d", i), 64'(got), 64'(mk(exp_tog[i], -exp_tog[i])));
    end
    strobe(0, 0, 0, 0, mk(0, 0), got);

    // Saturating overdub, positive and negative, and write-back
    strobe(1, 0, 0, 0, mk('h7FFFF0, 'hFFFFFF), got);
    strobe(0, 0, 0, 0, mk(0, 0), got);
    strobe(0, 1, 0, 0, mk('h20, 'h800000), got);
    chk("ovd_sat", 64'(got), 64'(mk('h7FFFFF, 'h800000)));
    strobe(0, 0, 0, 0, mk(0, 0), got);
    strobe(0, 0, 1, 0, mk(0, 0), got);
    chk("ovd_stored", 64'(got), 64'(mk('h7FFFFF, 'h800000)));
    strobe(0, 0, 0, 0, mk(0, 0), got);

    // Fill to DEPTH with write held; further write is ignored until released
    for (int i = 0; i < 20; i++) begin
      strobe(1, 0, 0, 0, mk(100 + i, i), got);
      if (i == 15) chk("full_at16", 64'({full, state, loop_len}), 64'({1'b1, 3'(S_IDLE), 5'd16}));
    end
    chk("full_hold", 64'({full, state, loop_len}), 64'({1'b1, 3'(S_IDLE), 5'd16}));
    strobe(0, 0, 0, 0, mk(0, 0), got);
    for (int i = 0; i < 17; i++) begin
      strobe(0, 0, 1, 0, mk(0, 0), got);
      chk($sformatf("wrap16_%0d", i), 64'(got), 64'(mk(100 + (i % 16), i % 16)));
    end

    // Reset between edges while a play strobe is pending
    read = 1'b1; reverse = 1'b0; sample_en = 1'b1;
    @(posedge clk); #1 sample_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst", 64'({out_valid, state, loop_len}), 64'(0));
    chk("mid_rst_out", 64'(out), 64'(0));
    @(posedge clk); #1 chk("mid_rst_novalid", 64'(out_valid), 64'(0));
    model_reset();
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    strobe(0, 0, 1, 0, mk(1234, -99), got);
    chk("post_rst_passthru", 64'(got), 64'(mk(1234, -99)));

    // Randomized commands against the reference model
    for (int n = 0; n < 250; n++) begin
      int sel;
      bit w, o, r;
      logic [FW-1:0] d;
      sel = $urandom_range(0, 9);
      w = (sel < 3);
      o = (sel == 3 || sel == 4);
      r = (sel >= 5 && sel <= 7);
      if (sel == 9) begin w = $urandom_range(0, 1); o = $urandom_range(0, 1); r = 1; end
      d = {24'($urandom), 24'($urandom)};
      if ($urandom_range(0, 3) == 0) d = {DW'(1) << (DW-1), {1'b0, {(DW-1){1'b1}}}};
      strobe(w, o, r, 1'($urandom_range(0, 1)), d, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/audio_looper_mc.md
Name: audio_looper_mc

Overview:
Parametrised multi-channel loop recorder/player for the audio codec path, replacing the single-channel looper. It records strobed samples into an on-chip buffer and plays them back forward or reversed with a tracked loop length. It adds overdub (saturating mix into the loop), full detection and auto-stop. It sits between the codec input deserialiser and the output serialiser, and it advances only on the codec sample strobe.

Parameters:
DATA_WIDTH, 24, signed two's-complement bits per channel sample
NUM_CH, 2, channel count; all channels share one address pointer
ADDR_WIDTH, 4, buffer depth DEPTH = 2**ADDR_WIDTH frames

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low (0 = reset asserted)
sample_en  input  1  one-cycle sample strobe; consecutive strobes are at least 3 clk cycles apart
in  input  NUM_CH*DATA_WIDTH  input frame; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
write  input  1  level: record a new loop
overdub  input  1  level: mix input into the existing loop
read  input  1  level: play the loop
reverse  input  1  level: playback direction (1 = backwards)
out  output  NUM_CH*DATA_WIDTH  registered output frame
out_valid  output  1  one-cycle pulse when out updates
loop_len  output  ADDR_WIDTH+1  frames in the current loop (0..DEPTH)
state  output  3  0 EMPTY, 1 RECORD, 2 IDLE, 3 PLAY, 4 OVERDUB
full  output  1  high while loop_len == DEPTH

Behaviour:
- Reset (async assert, sync release): out=0, out_valid=0, state=EMPTY, loop_len=0, ptr=0, full=0. Buffer contents are not cleared.
- Command priority: write > overdub > read. State is evaluated only on the sample_en cycle (cycle S).
- EMPTY: out=in. write -> RECORD; all other commands are ignored.
- RECORD entry from any other state: ptr=0, loop_len=0 (the old loop is discarded).
  - Each strobe: mem[ptr] <= in, ptr++, loop_len++, out=in.
  - write low at a strobe: recording ends -> IDLE if loop_len>0, else EMPTY.
  - Frame DEPTH written: full=1, state -> IDLE. write stays ignored until it has been seen low at one strobe.
- IDLE: out=in. overdub -> OVERDUB, read -> PLAY.
- PLAY/OVERDUB entry from IDLE: ptr = reverse ? loop_len-1 : 0. A direct PLAY<->OVERDUB change keeps ptr.
- Pointer step per strobe:
  - Forward: loop_len-1 wraps to 0.
  - Reverse: 0 wraps to loop_len-1.
  - A reverse change mid-play continues from the current ptr in the new direction, with no jump.
- PLAY: out = mem[ptr].
- OVERDUB: per channel, out = sat(mem[ptr] + in). The same saturated value is written back to mem[ptr]. Sum is DATA_WIDTH+1 bits, clamped to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
- No read/overdub/write at a strobe in PLAY or OVERDUB -> IDLE.
- Timing: buffer address is presented in cycle S; synchronous read data arrives in S+1. In S+1, out is registered, out_valid pulses, and any overdub write-back occurs. Latency is strobe -> out_valid = 1 clk.
- Pointer/state update at S+1. sample_en arriving during S+1 is a protocol violation; an assertion must flag it.
- Reset mid-record or mid-play aborts immediately. The loop is lost (loop_len=0).

Test Plan:
1. DW=24, NUM_CH=2, ADDR_WIDTH=4, ramp in (ch0=n, ch1=-n). Reset, write high for 5 strobes (n=1..5), then low -> loop_len=5, state=IDLE, out tracked in during the record.
2. read, reverse=0 for 12 strobes -> out ch0 = 1,2,3,4,5,1,2,3,4,5,1,2 and ch1 negated, with out_valid exactly 1 clk after each strobe.
3. From IDLE, read with reverse=1 -> 5,4,3,2,1,5. Toggle reverse to 0 after the value 3 -> next outputs 4,5,1.
4. Overdub: mem ch0 = 0x7FFFF0, input 0x000020 -> out and stored value 0x7FFFFF. Input 0x800000 onto 0xFFFFFF -> 0x800000 (negative saturation).
5. write held for 20 strobes -> full=1 after 16 frames, state=IDLE, loop_len=16. Write is ignored until it drops. Then read -> 16-frame wrap.
6. Assert reset low mid-PLAY (between clk edges) -> out=0, state=EMPTY, loop_len=0 immediately. read after release -> out=in.
